// File: rtl/mult_pkg.sv
// Shared definitions for the tiled multiplier family: tile width, sequencer states,
// and the per-operand tile count.
package mult_pkg;

    localparam int TILE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    function automatic int tile_count(input int width);
        return width / TILE_W;
    endfunction

endpackage

// File: rtl/mult4_tile.sv
// Combinational 4x4 unsigned multiplier tile with an 8-bit product.
// Interface is shared with the combinational multipliers so alternative tile netlists can be swapped in.
module mult4_tile (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = 8'(a) * 8'(b);

endmodule

// File: rtl/mult_tiled_seq.sv
// Sequential WIDTH x WIDTH multiplier: one 4x4 tile reused over (WIDTH/4)^2 cycles,
// sign-magnitude handling for signed operands, valid/ready on both sides.
module mult_tiled_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int N  = tile_count(WIDTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if ((WIDTH % TILE_W) != 0 || WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("mult_tiled_seq: WIDTH must be a multiple of 4 in 8..32");
    end

    state_t        state, state_nx;
    logic [WIDTH-1:0] a_mag, b_mag, a_abs, b_abs;
    logic          neg;
    logic [PW-1:0] acc, term, sum, p_reg;
    logic [IW-1:0] i_idx, j_idx;
    logic [3:0]    a_nib, b_nib;
    logic [7:0]    tile_p;
    logic          last_tile, accept, out_valid_q;

    assign accept    = in_valid & in_ready;
    assign last_tile = (i_idx == LAST) && (j_idx == LAST);
    assign a_abs     = (in_signed & A[WIDTH-1]) ? -A : A;
    assign b_abs     = (in_signed & B[WIDTH-1]) ? -B : B;

    assign a_nib = a_mag[i_idx*TILE_W +: TILE_W];
    assign b_nib = b_mag[j_idx*TILE_W +: TILE_W];

    mult4_tile u_tile (
        .a (a_nib),
        .b (b_nib),
        .p (tile_p)
    );

    assign term = PW'(tile_p) << (TILE_W * (int'(i_idx) + int'(j_idx)));
    assign sum  = acc + term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = MUL;
            MUL:     if (last_tile) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        busy      = (state == MUL) || (state == DONE);
        out_valid = out_valid_q;
        P         = p_reg;
    end

    // The final term is folded straight into P so the result lands on the last MUL edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_mag       <= '0;
            b_mag       <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            p_reg       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_mag <= a_abs;
                        b_mag <= b_abs;
                        neg   <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                    end
                end
                MUL: begin
                    acc <= sum;
                    if (j_idx == LAST) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                    if (last_tile) begin
                        p_reg       <= neg ? -sum : sum;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_tiled_seq.sv
// Directed and randomised checks of mult_tiled_seq at WIDTH = 8, 12, 16, 32 with a
// per-instance queue of expected products.
module tb_mult_tiled_seq;

    localparam int WS [4] = '{8, 12, 16, 32};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  iv, is_s, ordy;
    logic [3:0]  ir, ov, bz;
    logic [31:0] a_s [4];
    logic [31:0] b_s [4];
    logic [63:0] p_s [4];
    logic [63:0] sbq [4][$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = WS[g];
        logic [2*W-1:0] p_w;
        logic           irw, ovw, bzw;

        mult_tiled_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irw),
            .in_signed (is_s[g]),
            .A         (a_s[g][W-1:0]),
            .B         (b_s[g][W-1:0]),
            .out_valid (ovw),
            .out_ready (ordy[g]),
            .P         (p_w),
            .busy      (bzw)
        );

        assign ir[g]  = irw;
        assign ov[g]  = ovw;
        assign bz[g]  = bzw;
        assign p_s[g] = 64'(p_w);
    end

    function automatic logic [63:0] ref_prod(input int w, input logic sg,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        logic [63:0] ua, ub, pr, pm;
        longint      sa, sb;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = 64'(a & m);
        ub = 64'(b & m);
        if (sg) begin
            sa = longint'(ua);
            sb = longint'(ub);
            if (ua[w-1]) sa = sa - longint'(64'd1 << w);
            if (ub[w-1]) sb = sb - longint'(64'd1 << w);
            pr = 64'(sa * sb);
        end else begin
            pr = ua * ub;
        end
        pm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return pr & pm;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns just after the accept edge.
    task automatic launch(input int k, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        iv[k]   = 1'b1;
        is_s[k] = sg;
        a_s[k]  = a;
        b_s[k]  = b;
        sbq[k].push_back(exp);
        tick();
        iv[k]   = 1'b0;
        a_s[k]  = $urandom;
        b_s[k]  = $urandom;
        is_s[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input int k, output int cyc);
        cyc = 0;
        while (!ov[k] && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("out_valid_seen", 64'(ov[k]), 64'd1);
    endtask

    task automatic finish_txn(input int k, input string tag);
        logic [63:0] exp;
        exp = (sbq[k].size() > 0) ? sbq[k].pop_front() : 'x;
        chk(tag, p_s[k], exp);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input string tag);
        int lat;
        launch(k, sg, a, b, exp);
        wait_valid(k, lat);
        finish_txn(k, tag);
    endtask

    initial begin
        int lat, n;
        logic [63:0] hold;
        logic stable, flags_ok, done, sg;
        logic [31:0] a, b;

        rst_n = 1'b0;
        iv    = '0;
        is_s  = '0;
        ordy  = '0;
        for (int k = 0; k < 4; k++) begin
            a_s[k] = '0;
            b_s[k] = '0;
        end
        repeat (2) tick();
        chk("rst_in_ready",  64'(ir[0]), 64'd0);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_busy",      64'(bz[0]), 64'd0);
        chk("rst_P",         p_s[0],     64'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 64'(ir[0]), 64'd1);

        launch(0, 1'b0, 32'd255, 32'd255, 64'hFE01);
        chk("busy_in_mul", 64'(bz[0]), 64'd1);
        wait_valid(0, lat);
        chk("w8_latency", 64'(lat), 64'd4);
        finish_txn(0, "w8_u_ff_ff");

        run(0, 1'b1, 32'h80, 32'h80, 64'h4000, "w8_s_min_min");
        run(0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, "w8_s_m3_5");
        run(0, 1'b1, 32'h00, 32'h80, 64'h0000, "w8_s_zero_neg");

        launch(0, 1'b0, 32'd12, 32'd13, 64'd156);
        wait_valid(0, lat);
        hold     = p_s[0];
        iv[0]    = 1'b1;
        is_s[0]  = 1'b0;
        a_s[0]   = 32'd3;
        b_s[0]   = 32'd4;
        stable   = 1'b1;
        flags_ok = 1'b1;
        repeat (10) begin
            tick();
            if (p_s[0] !== hold) stable = 1'b0;
            if (ir[0] !== 1'b0 || ov[0] !== 1'b1) flags_ok = 1'b0;
        end
        chk("stall_flags", 64'({stable, flags_ok}), 64'd3);
        finish_txn(0, "stall_result");
        chk("idle_after_handshake", 64'(ir[0]), 64'd1);
        sbq[0].push_back(64'd12);
        tick();
        iv[0] = 1'b0;
        wait_valid(0, lat);
        chk("held_valid_latency", 64'(lat), 64'd4);
        finish_txn(0, "held_valid_result");

        launch(0, 1'b0, 32'd3, 32'd3, 64'd9);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_P",         p_s[0],     64'd0);
        chk("abort_in_ready",  64'(ir[0]), 64'd1);
        void'(sbq[0].pop_front());
        run(0, 1'b0, 32'd7, 32'd9, 64'd63, "w8_after_abort");

        launch(2, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001);
        wait_valid(2, lat);
        chk("w16_latency", 64'(lat), 64'd16);
        finish_txn(2, "w16_u_ffff");
        run(2, 1'b1, 32'h8000, 32'h7FFF, 64'hC000_8000, "w16_s_min_max");

        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 20; t++) begin
                repeat ($urandom_range(0, 2)) tick();
                a  = $urandom;
                b  = $urandom;
                sg = 1'($urandom_range(0, 1));
                if (t == 0) begin
                    a = 32'h8000_0000 >> (32 - WS[k]);
                    b = a;
                    sg = 1'b1;
                end
                launch(k, sg, a, b, ref_prod(WS[k], sg, a, b));
                n    = 0;
                done = 1'b0;
                while (!done && n < 400) begin
                    if (ov[k] && $urandom_range(0, 2) == 0) begin
                        finish_txn(k, "random_product");
                        done = 1'b1;
                    end else begin
                        tick();
                        n++;
                    end
                end
                chk("random_completed", 64'(done), 64'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
